// File: rtl/sopc_rst_ctrl_if.sv
// Status and control bundle between the board reset controller and the CPU side.
// The CPU side (master) requests resets and kicks the watchdog; the controller answers with status.
interface sopc_rst_ctrl_if #(
  parameter int WDT_WIDTH = 16,
  parameter int CNT_WIDTH = 8
);
  logic                 sw_rst_req;
  logic                 wdt_en;
  logic                 wdt_kick;
  logic [WDT_WIDTH-1:0] wdt_timeout;
  logic                 rst_out;
  logic                 ready;
  logic [1:0]           rst_cause;
  logic [CNT_WIDTH-1:0] rst_events;

  modport master (
    output sw_rst_req, wdt_en, wdt_kick, wdt_timeout,
    input  rst_out, ready, rst_cause, rst_events
  );

  modport slave (
    input  sw_rst_req, wdt_en, wdt_kick, wdt_timeout,
    output rst_out, ready, rst_cause, rst_events
  );
endinterface

// File: rtl/sopc_rst_ctrl.sv
// Board reset controller: synchronised external release, fixed hold time,
// CPU soft reset, watchdog, and last-cause / event bookkeeping for the sopc core.
module sopc_rst_ctrl #(
  parameter int HOLD_CYCLES = 16,
  parameter int WDT_WIDTH   = 16,
  parameter int CNT_WIDTH   = 8
) (
  input  logic CLOCK_50,
  input  logic rst,
  sopc_rst_ctrl_if.slave bus
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RESET,
    S_HOLD,
    S_RUN
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [WDT_WIDTH-1:0] wdt_q, wdt_d;
  logic [1:0]           cause_q, cause_d;
  logic [CNT_WIDTH-1:0] ev_q, ev_d;
  logic                 rst_out_q, rst_out_d;

  logic wdt_off;
  logic wdt_exp;
  logic [CNT_WIDTH-1:0] ev_inc;

  assign wdt_off = !bus.wdt_en || (bus.wdt_timeout == '0);
  assign wdt_exp = !wdt_off && !bus.wdt_kick
                && (wdt_q == bus.wdt_timeout - 1'b1);
  assign ev_inc  = (&ev_q) ? ev_q : ev_q + 1'b1;

  always_comb begin
    state_d = state_q;
    sync_d  = {sync_q[0], 1'b0};
    hold_d  = hold_q;
    wdt_d   = wdt_q;
    cause_d = cause_q;
    ev_d    = ev_q;
    unique case (state_q)
      S_RESET: begin
        // release leaving the first stage is caught by the second on this edge
        if (!sync_q[0] && sync_q[1]) begin
          state_d = S_HOLD;
          hold_d  = '0;
        end
      end
      S_HOLD: begin
        wdt_d = '0;
        if (hold_q == HOLD_LAST) begin
          state_d = S_RUN;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_RUN: begin
        wdt_d = (wdt_off || bus.wdt_kick) ? '0 : wdt_q + 1'b1;
        if (bus.sw_rst_req) begin
          state_d = S_HOLD;
          hold_d  = '0;
          wdt_d   = '0;
          cause_d = 2'b01;
          ev_d    = ev_inc;
        end else if (wdt_exp) begin
          state_d = S_HOLD;
          hold_d  = '0;
          wdt_d   = '0;
          cause_d = 2'b10;
          ev_d    = ev_inc;
        end
      end
      default: begin
        state_d = S_RESET;
      end
    endcase
    rst_out_d = (state_d != S_RUN);
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state_q   <= S_RESET;
      sync_q    <= 2'b11;
      hold_q    <= '0;
      wdt_q     <= '0;
      cause_q   <= 2'b00;
      ev_q      <= '0;
      rst_out_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      hold_q    <= hold_d;
      wdt_q     <= wdt_d;
      cause_q   <= cause_d;
      ev_q      <= ev_d;
      rst_out_q <= rst_out_d;
    end
  end

  assign bus.rst_out    = rst_out_q;
  assign bus.ready      = ~rst_out_q;
  assign bus.rst_cause  = cause_q;
  assign bus.rst_events = ev_q;

endmodule

// File: tb/tb_sopc_rst_ctrl.sv
// Scoreboard bench for sopc_rst_ctrl: stimulus queues expected rst_out edges
// and probes; a negedge monitor pops and compares them.
module tb_sopc_rst_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;

  sopc_rst_ctrl_if #(.WDT_WIDTH(16), .CNT_WIDTH(8)) bus ();

  sopc_rst_ctrl #(
    .HOLD_CYCLES(16),
    .WDT_WIDTH  (16),
    .CNT_WIDTH  (8)
  ) dut (
    .CLOCK_50(clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       ro;
    logic [1:0] cause;
    logic [7:0] ev;
    bit         probe;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   checks   = 0;
  int   failures = 0;
  logic prev_ro  = 1'b1;

  task automatic push(int c, logic ro, logic [1:0] ca, logic [7:0] ev,
                      bit pr);
    exp_t e;
    e.cyc   = c;
    e.ro    = ro;
    e.cause = ca;
    e.ev    = ev;
    e.probe = pr;
    q.push_back(e);
  endtask

  task automatic to_cyc(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse_sw();
    bus.sw_rst_req = 1'b1;
    @(negedge clk);
    bus.sw_rst_req = 1'b0;
  endtask

  task automatic pulse_kick();
    bus.wdt_kick = 1'b1;
    @(negedge clk);
    bus.wdt_kick = 1'b0;
  endtask

  task automatic compare(exp_t e);
    checks++;
    if (cyc != e.cyc || bus.rst_out !== e.ro || bus.ready !== ~e.ro ||
        bus.rst_cause !== e.cause || bus.rst_events !== e.ev) begin
      failures++;
      $display("FAIL %s cyc=%0d/%0d rst_out=%b/%b ready=%b cause=%b/%b ev=%0d/%0d",
               e.probe ? "probe" : "edge", cyc, e.cyc, bus.rst_out, e.ro,
               bus.ready, bus.rst_cause, e.cause, bus.rst_events, e.ev);
    end
  endtask

  always @(negedge clk) begin
    if (bus.rst_out !== prev_ro) begin
      prev_ro = bus.rst_out;
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_edge cyc=%0d rst_out=%b cause=%b ev=%0d",
                 cyc, bus.rst_out, bus.rst_cause, bus.rst_events);
      end else begin
        m = q.pop_front();
        compare(m);
      end
    end else if (q.size() > 0 && q[0].probe && q[0].cyc == cyc) begin
      m = q.pop_front();
      compare(m);
    end else if (q.size() > 0 && q[0].cyc < cyc) begin
      m = q.pop_front();
      checks++;
      failures++;
      $display("FAIL missed_event cyc=%0d expected_at=%0d rst_out=%b want=%b",
               cyc, m.cyc, bus.rst_out, m.ro);
    end
  end

  initial begin
    int c;
    int r;
    int k;
    int kk;
    int r0;
    bus.sw_rst_req  = 1'b0;
    bus.wdt_en      = 1'b0;
    bus.wdt_kick    = 1'b0;
    bus.wdt_timeout = '0;

    // power-on reset, released at 195ns
    #1 rst = 1'b1;
    push(1, 1'b1, 2'b00, 8'd0, 1'b1);
    push(5, 1'b1, 2'b00, 8'd0, 1'b1);
    #194 rst = 1'b0;
    r0 = cyc;
    push(r0 + 18, 1'b0, 2'b00, 8'd0, 1'b0);
    to_cyc(r0 + 22);

    // soft reset
    c = cyc;
    push(c + 1,  1'b1, 2'b01, 8'd1, 1'b0);
    push(c + 17, 1'b0, 2'b01, 8'd1, 1'b0);
    pulse_sw();
    to_cyc(c + 20);

    // watchdog expiry, twice without kicks
    c = cyc;
    bus.wdt_timeout = 16'd100;
    bus.wdt_en      = 1'b1;
    push(c + 100, 1'b1, 2'b10, 8'd2, 1'b0);
    push(c + 116, 1'b0, 2'b10, 8'd2, 1'b0);
    push(c + 216, 1'b1, 2'b10, 8'd3, 1'b0);
    push(c + 232, 1'b0, 2'b10, 8'd3, 1'b0);
    r = c + 232;
    for (int i = 0; i < 20; i++) begin
      to_cyc(r + 40 + 50 * i);
      pulse_kick();
    end
    k = r + 40 + 50 * 19;
    push(k + 60, 1'b0, 2'b10, 8'd3, 1'b1);

    // kick lands on the expiry cycle
    kk = k + 100;
    to_cyc(kk);
    pulse_kick();

    // soft request lands on the expiry cycle
    to_cyc(kk + 100);
    push(kk + 101, 1'b1, 2'b01, 8'd4, 1'b0);
    push(kk + 117, 1'b0, 2'b01, 8'd4, 1'b0);
    pulse_sw();
    bus.wdt_en = 1'b0;
    to_cyc(kk + 120);

    // sub-cycle external glitch in the middle of a soft-reset hold
    c = cyc;
    push(c + 1, 1'b1, 2'b01, 8'd5, 1'b0);
    pulse_sw();
    to_cyc(c + 6);
    #5 rst = 1'b1;
    #4 rst = 1'b0;
    r0 = cyc;
    push(r0 + 1, 1'b1, 2'b00, 8'd0, 1'b1);
    push(r0 + 18, 1'b0, 2'b00, 8'd0, 1'b0);
    to_cyc(r0 + 22);

    // zero timeout keeps the watchdog off
    bus.wdt_timeout = '0;
    bus.wdt_en      = 1'b1;
    c = cyc;
    push(c + 35000, 1'b0, 2'b00, 8'd0, 1'b1);
    push(c + 70000, 1'b0, 2'b00, 8'd0, 1'b1);
    to_cyc(c + 70002);
    bus.wdt_en = 1'b0;

    // event counter saturation
    for (int n = 1; n <= 258; n++) begin
      logic [7:0] ev;
      ev = (n > 255) ? 8'hFF : 8'(n);
      c = cyc;
      push(c + 1,  1'b1, 2'b01, ev, 1'b0);
      push(c + 17, 1'b0, 2'b01, ev, 1'b0);
      pulse_sw();
      to_cyc(c + 18);
    end

    to_cyc(cyc + 5);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL leftover_expectations pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
